// File: rtl/hub75_stream_loader_pkg.sv
// Shared types for the HUB75 stream loader: FSM state encoding.
package hub75_stream_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ROW_STORE,
        ST_ROW_FLUSH,
        ST_FRAME_SWAP,
        ST_FRAME_WAIT
    } state_t;

endpackage

// File: rtl/hub75_stream_loader.sv
// Feeds a raster pixel stream into the hub75_top frame buffer write port: fills the line
// buffer, stores each line into the back buffer and requests a frame swap at frame end.
module hub75_stream_loader
    import hub75_stream_loader_pkg::*;
#(
    parameter int N_BANKS     = 2,
    parameter int N_ROWS      = 32,
    parameter int N_COLS      = 64,
    parameter int BITDEPTH    = 24,
    parameter int LOG_N_BANKS = $clog2(N_BANKS),
    parameter int LOG_N_ROWS  = $clog2(N_ROWS),
    parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BITDEPTH-1:0]    in_data,
    input  logic                   in_sof,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [LOG_N_BANKS-1:0] fbw_bank_addr,
    output logic [LOG_N_ROWS-1:0]  fbw_row_addr,
    output logic                   fbw_row_store,
    input  logic                   fbw_row_rdy,
    output logic                   fbw_row_swap,
    output logic [BITDEPTH-1:0]    fbw_data,
    output logic [LOG_N_COLS-1:0]  fbw_col_addr,
    output logic                   fbw_wren,
    output logic                   frame_swap,
    input  logic                   frame_rdy,
    output logic                   stat_busy,
    output logic                   stat_resync
);

    localparam int Y_W    = LOG_N_BANKS + LOG_N_ROWS;
    localparam int LAST_Y = N_BANKS * N_ROWS - 1;

    state_t                state, state_next;
    logic [LOG_N_COLS-1:0] col;
    logic [Y_W-1:0]        y;
    logic                  settle;

    logic accept, write_en, restart, store_fire, swap_fire, frame_done;
    logic last_col, last_line;

    assign in_ready  = (state == ST_IDLE) || (state == ST_FILL);
    assign accept    = in_valid && in_ready;
    assign last_col  = (col == LOG_N_COLS'(N_COLS - 1));
    assign last_line = (y == Y_W'(LAST_Y));
    assign stat_busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        write_en   = 1'b0;
        restart    = 1'b0;
        store_fire = 1'b0;
        swap_fire  = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && in_sof) begin
                    write_en   = 1'b1;
                    restart    = 1'b1;
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    write_en = 1'b1;
                    if (in_sof)        restart    = 1'b1;
                    else if (last_col) state_next = ST_ROW_STORE;
                end
            end
            ST_ROW_STORE: begin
                if (fbw_row_rdy) begin
                    store_fire = 1'b1;
                    state_next = last_line ? ST_ROW_FLUSH : ST_FILL;
                end
            end
            // settle masks the stale ready for one cycle after our own request
            ST_ROW_FLUSH: begin
                if (!settle && fbw_row_rdy) state_next = ST_FRAME_SWAP;
            end
            ST_FRAME_SWAP: begin
                if (frame_rdy) begin
                    swap_fire  = 1'b1;
                    state_next = ST_FRAME_WAIT;
                end
            end
            ST_FRAME_WAIT: begin
                if (!settle && frame_rdy) begin
                    frame_done = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col           <= '0;
            y             <= '0;
            settle        <= 1'b0;
            fbw_wren      <= 1'b0;
            fbw_data      <= '0;
            fbw_col_addr  <= '0;
            fbw_row_store <= 1'b0;
            fbw_row_swap  <= 1'b0;
            fbw_bank_addr <= '0;
            fbw_row_addr  <= '0;
            frame_swap    <= 1'b0;
            stat_resync   <= 1'b0;
        end else begin
            fbw_wren      <= write_en;
            fbw_row_store <= store_fire;
            fbw_row_swap  <= store_fire;
            frame_swap    <= swap_fire;
            stat_resync   <= restart && (state == ST_FILL);
            settle        <= (store_fire && last_line) || swap_fire;

            if (write_en) begin
                fbw_data     <= in_data;
                fbw_col_addr <= restart ? '0 : col;
            end

            if (store_fire) begin
                fbw_bank_addr <= y[Y_W-1 -: LOG_N_BANKS];
                fbw_row_addr  <= y[LOG_N_ROWS-1:0];
            end

            if (restart) begin
                col <= LOG_N_COLS'(1);
                y   <= '0;
            end else if (write_en) begin
                col <= col + LOG_N_COLS'(1);
            end else if (store_fire) begin
                col <= '0;
                if (!last_line) y <= y + Y_W'(1);
            end else if (frame_done) begin
                col <= '0;
                y   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hub75_stream_loader.sv
// Directed bench for hub75_stream_loader with a small frame-buffer ready model and scoreboards.
module tb_hub75_stream_loader;

    localparam int NB = 2, NR = 4, NC = 8, BD = 24;
    localparam int NPX = NB * NR * NC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BD-1:0] in_data = '0;
    logic          in_sof = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [0:0]    fbw_bank_addr;
    logic [1:0]    fbw_row_addr;
    logic          fbw_row_store, fbw_row_rdy, fbw_row_swap;
    logic [BD-1:0] fbw_data;
    logic [2:0]    fbw_col_addr;
    logic          fbw_wren, frame_swap, frame_rdy, stat_busy, stat_resync;

    hub75_stream_loader #(.N_BANKS(NB), .N_ROWS(NR), .N_COLS(NC), .BITDEPTH(BD)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid), .in_ready(in_ready),
        .fbw_bank_addr(fbw_bank_addr), .fbw_row_addr(fbw_row_addr),
        .fbw_row_store(fbw_row_store), .fbw_row_rdy(fbw_row_rdy), .fbw_row_swap(fbw_row_swap),
        .fbw_data(fbw_data), .fbw_col_addr(fbw_col_addr), .fbw_wren(fbw_wren),
        .frame_swap(frame_swap), .frame_rdy(frame_rdy),
        .stat_busy(stat_busy), .stat_resync(stat_resync)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Frame-buffer model and output monitor, both on the falling edge.
    int ncyc = 0;
    int row_hold = 3, frame_hold = 10;
    int row_cnt = 0, frame_cnt = 0;
    bit frame_block = 0;
    int rdy_rise = 0;
    int wr_col_q[$], wr_dat_q[$], wr_cyc_q[$];
    int st_bank_q[$], st_row_q[$], st_cyc_q[$];
    int exp_col_q[$], exp_dat_q[$], exp_bank_q[$], exp_row_q[$];
    int swap_n = 0, swap_cyc = 0, resync_n = 0, pair_bad = 0;

    initial begin
        fbw_row_rdy = 1'b1;
        frame_rdy   = 1'b1;
    end

    always @(negedge clk) begin
        ncyc++;
        if (fbw_wren) begin
            wr_col_q.push_back(int'(fbw_col_addr));
            wr_dat_q.push_back(int'(fbw_data));
            wr_cyc_q.push_back(ncyc);
        end
        if (fbw_row_store) begin
            st_bank_q.push_back(int'(fbw_bank_addr));
            st_row_q.push_back(int'(fbw_row_addr));
            st_cyc_q.push_back(ncyc);
        end
        if (fbw_row_store != fbw_row_swap) pair_bad++;
        if (frame_swap) begin
            swap_n++;
            swap_cyc = ncyc;
        end
        if (stat_resync) resync_n++;

        if (fbw_row_store) begin
            row_cnt     = row_hold;
            fbw_row_rdy = 1'b0;
        end else if (row_cnt > 0) begin
            row_cnt--;
            if (row_cnt == 0) begin
                fbw_row_rdy = 1'b1;
                rdy_rise    = ncyc;
            end
        end
        if (frame_swap) frame_cnt = frame_hold;
        else if (frame_cnt > 0) frame_cnt--;
        frame_rdy = (frame_cnt == 0) && !frame_block;
    end

    task automatic clear_sb();
        wr_col_q.delete(); wr_dat_q.delete(); wr_cyc_q.delete();
        st_bank_q.delete(); st_row_q.delete(); st_cyc_q.delete();
        exp_col_q.delete(); exp_dat_q.delete(); exp_bank_q.delete(); exp_row_q.delete();
        swap_n = 0; resync_n = 0; pair_bad = 0;
    endtask

    // Called at a falling edge; returns at the falling edge after the pixel is accepted.
    task automatic send_px(input int d, input bit sof, input bit expect_wr, input int x,
                           input bit gaps);
        bit acc = 0;
        if (gaps && $urandom_range(1) == 1) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_data  = BD'(d);
        in_sof   = sof;
        in_valid = 1'b1;
        for (int k = 0; k < 300 && !acc; k++) begin
            if (in_ready) acc = 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
        if (expect_wr) begin
            exp_col_q.push_back(x);
            exp_dat_q.push_back(d);
        end
    endtask

    task automatic send_lines(input int npx, input bit gaps);
        for (int p = 0; p < npx; p++)
            send_px((p / NC) * NC + (p % NC), p == 0, 1'b1, p % NC, gaps);
    endtask

    task automatic expect_stores(input int n);
        for (int i = 0; i < n; i++) begin
            exp_bank_q.push_back(i / NR);
            exp_row_q.push_back(i % NR);
        end
    endtask

    task automatic wait_idle(input string tag);
        bit done = 0;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(negedge clk);
            if (!stat_busy) done = 1;
        end
        if (!done) check({tag, "_idle_timeout"}, 0, 1);
    endtask

    task automatic compare(input string tag);
        check({tag, "_wren_n"}, wr_col_q.size(), exp_col_q.size());
        for (int i = 0; i < wr_col_q.size() && i < exp_col_q.size(); i++) begin
            check({tag, "_col"}, wr_col_q[i], exp_col_q[i]);
            check({tag, "_data"}, wr_dat_q[i], exp_dat_q[i]);
        end
        check({tag, "_store_n"}, st_bank_q.size(), exp_bank_q.size());
        for (int i = 0; i < st_bank_q.size() && i < exp_bank_q.size(); i++) begin
            check({tag, "_bank"}, st_bank_q[i], exp_bank_q[i]);
            check({tag, "_row"}, st_row_q[i], exp_row_q[i]);
        end
        check({tag, "_store_swap_pair"}, pair_bad, 0);
    endtask

    // For an uninterrupted frame: each store comes after the wren of its line's last pixel.
    task automatic check_store_order(input string tag);
        for (int i = 0; i < st_cyc_q.size(); i++)
            if (i * NC + NC - 1 < wr_cyc_q.size())
                check({tag, "_store_after_wren"},
                      32'(st_cyc_q[i] > wr_cyc_q[i * NC + NC - 1]), 1);
    endtask

    initial begin
        int rel, bad_rdy;

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_wren", fbw_wren, 0);
        check("rst_store", fbw_row_store, 0);
        check("rst_rswap", fbw_row_swap, 0);
        check("rst_fswap", frame_swap, 0);
        check("rst_busy", stat_busy, 0);
        check("rst_resync", stat_resync, 0);
        check("rst_col", fbw_col_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: clean frame
        clear_sb();
        send_lines(NPX, 1'b0);
        expect_stores(NB * NR);
        wait_idle("t1");
        compare("t1");
        check_store_order("t1");
        check("t1_fswap_n", swap_n, 1);
        check("t1_fswap_after_rdy", 32'(swap_cyc > rdy_rise), 1);
        check("t1_resync_n", resync_n, 0);

        // 2: leading non-SOF pixels are discarded
        clear_sb();
        for (int i = 0; i < 5; i++) send_px(100 + i, 1'b0, 1'b0, 0, 1'b0);
        check("t2_discard_no_wren", wr_col_q.size(), 0);
        send_lines(NPX, 1'b0);
        expect_stores(NB * NR);
        wait_idle("t2");
        compare("t2");
        check("t2_fswap_n", swap_n, 1);

        // 3: SOF at pixel 20 restarts the frame
        clear_sb();
        send_lines(20, 1'b0);
        expect_stores(2);
        send_lines(NPX, 1'b0);
        expect_stores(NB * NR);
        wait_idle("t3");
        compare("t3");
        check("t3_resync_n", resync_n, 1);
        check("t3_fswap_n", swap_n, 1);

        // 4: frame_rdy withheld 50 cycles at frame end
        clear_sb();
        frame_block = 1;
        send_lines(NPX, 1'b0);
        expect_stores(NB * NR);
        bad_rdy = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) bad_rdy++;
        end
        check("t4_in_ready_low", bad_rdy, 0);
        check("t4_no_early_fswap", swap_n, 0);
        check("t4_busy_waiting", stat_busy, 1);
        frame_block = 0;
        rel = ncyc;
        wait_idle("t4");
        compare("t4");
        check("t4_fswap_n", swap_n, 1);
        check("t4_fswap_after_release", 32'(swap_cyc > rel), 1);
        clear_sb();
        send_lines(NPX, 1'b0);
        expect_stores(NB * NR);
        wait_idle("t4b");
        compare("t4b");
        check("t4b_fswap_n", swap_n, 1);

        // 5: random valid gaps and a slower row ready
        clear_sb();
        row_hold = 6;
        send_lines(NPX, 1'b1);
        expect_stores(NB * NR);
        wait_idle("t5");
        compare("t5");
        check_store_order("t5");
        check("t5_fswap_n", swap_n, 1);
        row_hold = 3;

        // 6: reset in the middle of line 3
        clear_sb();
        send_lines(3 * NC + 4, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("t6_in_ready", in_ready, 1);
        check("t6_wren", fbw_wren, 0);
        check("t6_store", fbw_row_store, 0);
        check("t6_fswap", frame_swap, 0);
        check("t6_busy", stat_busy, 0);
        check("t6_data", fbw_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_sb();
        send_lines(NPX, 1'b0);
        expect_stores(NB * NR);
        wait_idle("t6");
        compare("t6");
        check("t6_fswap_n", swap_n, 1);
        check("t6_resync_n", resync_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
